vm_mem_arbiter: RTL and testbench

//  Shares the node's single-port Vm SRAM between the work pipeline (soma read-modify-write) and
//  the configurator (host Vm read/write). Owns an internal clear sweeper that zeroes Vm[0..neu_num-1]
//  on request. Sits between config_top's work/config paths and the Vm memory macro.

---
 rtl/vm_arb_pkg.sv | 28 ++
 rtl/vm_clear_sweeper.sv | 88 ++++++++
 rtl/vm_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vm_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_arb_pkg.sv
// ============================================================================
// Module   : vm_arb_pkg
// Purpose  : Shared encodings for the Vm SRAM arbiter: sweep FSM states and
//            requester identifiers used to tag the read-return pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vm_arb_pkg;

    // Clear-sweep FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    // Owner of an SRAM access; only WORK/CFG reads ever produce an rvalid
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_WORK = 2'd1,
        REQ_CFG  = 2'd2,
        REQ_CLR  = 2'd3
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/vm_clear_sweeper.sv
// ============================================================================
// Module   : vm_clear_sweeper
// Purpose  : Clear-sweep sequencer. On clear_start (from IDLE) walks the
//            address counter 0..neu_num-1, one address per cycle, then
//            spends one cycle in DONE to pulse clear_done. neu_num==0 goes
//            straight to DONE without issuing any address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vm_clear_sweeper
    import vm_arb_pkg::*;
#(
    parameter int NNW = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear_start,
    input  logic [NNW-1:0] neu_num,
    output logic           sweep_idle,
    output logic           sweep_valid,
    output logic [NNW-1:0] sweep_addr,
    output logic           clear_done
);

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic [NNW-1:0] r_cnt;
    logic [NNW-1:0] w_cnt_next;
    logic [NNW-1:0] r_last;
    logic [NNW-1:0] w_last_next;

    // State, address counter and latched final address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_last  <= w_last_next;
        end
    end

    // Next-state logic; neu_num is latched so it may change mid-sweep
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_cnt_next = '0;
                    if (neu_num == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_CLEAR;
                        w_last_next  = neu_num - NNW'(1);
                    end
                end
            end
            ST_CLEAR: begin
                if (r_cnt == r_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + NNW'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign sweep_idle  = (r_state == ST_IDLE);
    assign sweep_valid = (r_state == ST_CLEAR);
    assign sweep_addr  = r_cnt;
    assign clear_done  = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: rtl/vm_mem_arbiter.sv
// ============================================================================
// Module   : vm_mem_arbiter
// Purpose  : Shares the single-port Vm SRAM between the work pipeline, the
//            configurator and an internal clear sweeper. Priority per cycle:
//            sweep > work > config. Commands are registered onto mem_* one
//            cycle after grant; read data returns one cycle later with the
//            owner's rvalid pulsed.
// Options  : VM_ARB_STARVE_GUARD_EN - lets config win a contested cycle after
//            STARVE_MAX consecutive losses to work.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vm_mem_arbiter
    import vm_arb_pkg::*;
#(
    parameter int          NNW        = 12,
    parameter int          VW         = 20,
    parameter logic [VW-1:0] CLEAR_VAL = '0,
    parameter int          STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           work_req,
    input  logic           work_we,
    input  logic [NNW-1:0] work_addr,
    input  logic [VW-1:0]  work_wdata,
    output logic           work_gnt,
    output logic           work_rvalid,
    input  logic           cfg_req,
    input  logic           cfg_we,
    input  logic [NNW-1:0] cfg_addr,
    input  logic [VW-1:0]  cfg_wdata,
    output logic           cfg_gnt,
    output logic           cfg_rvalid,
    input  logic           clear_start,
    input  logic [NNW-1:0] neu_num,
    output logic           clear_busy,
    output logic           clear_done,
    output logic           mem_en,
    output logic           mem_we,
    output logic [NNW-1:0] mem_addr,
    output logic [VW-1:0]  mem_wdata,
    input  logic [VW-1:0]  mem_rdata
);

    logic           w_sweep_idle;
    logic           w_sweep_valid;
    logic [NNW-1:0] w_sweep_addr;
    logic           w_cfg_favored;
    logic           w_work_gnt;
    logic           w_cfg_gnt;
    logic           w_sel_en;
    logic           w_sel_we;
    logic [NNW-1:0] w_sel_addr;
    logic [VW-1:0]  w_sel_wdata;
    req_id_t        w_sel_tag;
    req_id_t        r_tag_q1;
    req_id_t        r_tag_q2;
    logic           r_mem_en;
    logic           r_mem_we;
    logic [NNW-1:0] r_mem_addr;
    logic [VW-1:0]  r_mem_wdata;
    logic           w_unused;

    vm_clear_sweeper #(
        .NNW (NNW)
    ) u_sweeper (
        .clk         (clk),
        .rst         (rst),
        .clear_start (clear_start),
        .neu_num     (neu_num),
        .sweep_idle  (w_sweep_idle),
        .sweep_valid (w_sweep_valid),
        .sweep_addr  (w_sweep_addr),
        .clear_done  (clear_done)
    );

`ifdef VM_ARB_STARVE_GUARD_EN
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    logic [c_STARVE_W-1:0] r_starve;

    assign w_cfg_favored = (r_starve == c_STARVE_W'(STARVE_MAX));

    // Count consecutive cycles config loses to work; saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_cfg_gnt || !cfg_req) begin
            r_starve <= '0;
        end else if (w_work_gnt && !w_cfg_favored) begin
            r_starve <= r_starve + c_STARVE_W'(1);
        end
    end

    assign w_unused = ^mem_rdata;
`else
    // Strict work-over-config priority
    assign w_cfg_favored = 1'b0;
    assign w_unused      = ^{mem_rdata, STARVE_MAX};
`endif

    // Grants only outside the sweep; work wins unless config is owed a turn
    assign w_work_gnt = w_sweep_idle & work_req & ~(cfg_req & w_cfg_favored);
    assign w_cfg_gnt  = w_sweep_idle & cfg_req & ~w_work_gnt;
    assign work_gnt   = w_work_gnt;
    assign cfg_gnt    = w_cfg_gnt;
    assign clear_busy = w_sweep_valid;

    // Select this cycle's SRAM command and the read-return owner
    always_comb begin
        w_sel_en    = 1'b0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_tag   = REQ_NONE;
        if (w_sweep_valid) begin
            w_sel_en    = 1'b1;
            w_sel_we    = 1'b1;
            w_sel_addr  = w_sweep_addr;
            w_sel_wdata = CLEAR_VAL;
        end else if (w_work_gnt) begin
            w_sel_en    = 1'b1;
            w_sel_we    = work_we;
            w_sel_addr  = work_addr;
            w_sel_wdata = work_wdata;
            w_sel_tag   = work_we ? REQ_NONE : REQ_WORK;
        end else if (w_cfg_gnt) begin
            w_sel_en    = 1'b1;
            w_sel_we    = cfg_we;
            w_sel_addr  = cfg_addr;
            w_sel_wdata = cfg_wdata;
            w_sel_tag   = cfg_we ? REQ_NONE : REQ_CFG;
        end
    end

    // SRAM command register; address/data hold while the macro is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_sel_en;
            r_mem_we <= w_sel_we;
            if (w_sel_en) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
        end
    end

    // Two-stage owner tag aligning rvalid with the SRAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_q1 <= REQ_NONE;
            r_tag_q2 <= REQ_NONE;
        end else begin
            r_tag_q1 <= w_sel_tag;
            r_tag_q2 <= r_tag_q1;
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign work_rvalid = (r_tag_q2 == REQ_WORK);
    assign cfg_rvalid  = (r_tag_q2 == REQ_CFG);

endmodule

`default_nettype wire

// File: tb/tb_vm_mem_arbiter.sv
// ============================================================================
// Module   : tb_vm_mem_arbiter
// Purpose  : Self-checking bench for vm_mem_arbiter: directed scenarios plus
//            randomized traffic against a queue/counter-level model and a
//            behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vm_mem_arbiter;

    localparam int NNW  = 12;
    localparam int VW   = 20;
    localparam int SMAX = 3;
    localparam logic [VW-1:0] CLR = '0;
`ifdef VM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           work_req, work_we, work_gnt, work_rvalid;
    logic [NNW-1:0] work_addr;
    logic [VW-1:0]  work_wdata;
    logic           cfg_req, cfg_we, cfg_gnt, cfg_rvalid;
    logic [NNW-1:0] cfg_addr;
    logic [VW-1:0]  cfg_wdata;
    logic           clear_start, clear_busy, clear_done;
    logic [NNW-1:0] neu_num;
    logic           mem_en, mem_we;
    logic [NNW-1:0] mem_addr;
    logic [VW-1:0]  mem_wdata;
    logic [VW-1:0]  mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vm_mem_arbiter #(
        .NNW        (NNW),
        .VW         (VW),
        .CLEAR_VAL  (CLR),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .work_req    (work_req),
        .work_we     (work_we),
        .work_addr   (work_addr),
        .work_wdata  (work_wdata),
        .work_gnt    (work_gnt),
        .work_rvalid (work_rvalid),
        .cfg_req     (cfg_req),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_gnt     (cfg_gnt),
        .cfg_rvalid  (cfg_rvalid),
        .clear_start (clear_start),
        .neu_num     (neu_num),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Behavioural single-port SRAM, 1-cycle read latency
    bit [VW-1:0] sram [0:(1<<NNW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit [VW-1:0] ref_mem [0:(1<<NNW)-1];
    int  sweep_left, sweep_addr, starve;
    bit  done_now;
    bit  ex_en, ex_we;
    int  ex_addr, ex_wdata;
    int  rv1_own, rv2_own;
    int  rv1_data, rv2_data;
    bit  last_wg, last_cg;
    bit  m_idle, m_fav, e_wg, e_cg;
    int  sl_old;
    bit  dn_old;

    // Single compare process: checks every output each cycle, then advances the model
    always @(negedge clk) begin : p_compare
        if (rst) begin
            sweep_left = 0; sweep_addr = 0; starve = 0; done_now = 0;
            ex_en = 0; ex_we = 0; ex_addr = 0; ex_wdata = 0;
            rv1_own = 0; rv2_own = 0; rv1_data = 0; rv2_data = 0;
            last_wg = 0; last_cg = 0;
            check("rst_mem_en",  32'(mem_en),      32'd0);
            check("rst_mem_we",  32'(mem_we),      32'd0);
            check("rst_busy",    32'(clear_busy),  32'd0);
            check("rst_done",    32'(clear_done),  32'd0);
            check("rst_wrvalid", 32'(work_rvalid), 32'd0);
            check("rst_crvalid", 32'(cfg_rvalid),  32'd0);
        end else begin
            m_idle = (sweep_left == 0) && !done_now;
            m_fav  = GUARD && (starve >= SMAX);
            e_wg   = m_idle && work_req && !(cfg_req && m_fav);
            e_cg   = m_idle && cfg_req && !e_wg;

            check("work_gnt",    32'(work_gnt),    32'(e_wg));
            check("cfg_gnt",     32'(cfg_gnt),     32'(e_cg));
            check("clear_busy",  32'(clear_busy),  32'(sweep_left > 0));
            check("clear_done",  32'(clear_done),  32'(done_now));
            check("mem_en",      32'(mem_en),      32'(ex_en));
            check("mem_we",      32'(mem_we),      32'(ex_we));
            if (ex_en) begin
                check("mem_addr",  32'(mem_addr),  ex_addr);
                check("mem_wdata", 32'(mem_wdata), ex_wdata);
            end
            check("work_rvalid", 32'(work_rvalid), 32'(rv2_own == 1));
            check("cfg_rvalid",  32'(cfg_rvalid),  32'(rv2_own == 2));
            if (rv2_own != 0) check("mem_rdata", 32'(mem_rdata), rv2_data);

            // command expected on mem_* next cycle
            rv2_own = rv1_own; rv2_data = rv1_data;
            rv1_own = 0;       rv1_data = 0;
            ex_en = 0; ex_we = 0;
            if (sweep_left > 0) begin
                ex_en = 1; ex_we = 1; ex_addr = sweep_addr; ex_wdata = int'(CLR);
                ref_mem[sweep_addr] = CLR;
            end else if (e_wg) begin
                ex_en = 1; ex_we = work_we; ex_addr = int'(work_addr); ex_wdata = int'(work_wdata);
                if (work_we) ref_mem[work_addr] = work_wdata;
                else begin rv1_own = 1; rv1_data = int'(ref_mem[work_addr]); end
            end else if (e_cg) begin
                ex_en = 1; ex_we = cfg_we; ex_addr = int'(cfg_addr); ex_wdata = int'(cfg_wdata);
                if (cfg_we) ref_mem[cfg_addr] = cfg_wdata;
                else begin rv1_own = 2; rv1_data = int'(ref_mem[cfg_addr]); end
            end

            // sweep progress
            sl_old = sweep_left; dn_old = done_now;
            if (sl_old > 0) begin
                sweep_addr++;
                sweep_left = sl_old - 1;
                if (sl_old == 1) done_now = 1;
            end else if (dn_old) begin
                done_now = 0;
            end else if (clear_start) begin
                if (neu_num == '0) done_now = 1;
                else begin sweep_left = int'(neu_num); sweep_addr = 0; end
            end

            // starvation bookkeeping
            if (e_cg || !cfg_req)         starve = 0;
            else if (e_wg && starve < SMAX) starve = starve + 1;

            last_wg = work_gnt;
            last_cg = cfg_gnt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cfg_gnt(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cfg_gnt) begin ok = 1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    bit wg_s [4];
    bit cg_s [4];

    initial begin : p_drive
        rst = 1'b1;
        work_req = 0; work_we = 0; work_addr = '0; work_wdata = '0;
        cfg_req = 0;  cfg_we = 0;  cfg_addr = '0;  cfg_wdata = '0;
        clear_start = 0; neu_num = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t1_idle_mem_en", 32'(mem_en), 32'd0);
            tick();
        end

        // 2: config write then read-back
        cfg_req = 1; cfg_we = 1; cfg_addr = NNW'(5); cfg_wdata = 20'h12345;
        wait_cfg_gnt("t2_wr_gnt");
        tick();
        cfg_we = 0;
        wait_cfg_gnt("t2_rd_gnt");
        tick();
        cfg_req = 0;
        @(negedge clk);
        check("t2_rvalid_early", 32'(cfg_rvalid), 32'd0);
        tick();
        @(negedge clk);
        check("t2_rvalid", 32'(cfg_rvalid), 32'd1);
        check("t2_rdata",  32'(mem_rdata),  32'h12345);
        tick();

        // 3: contested work/config
        work_req = 1; work_we = 0; work_addr = NNW'(1);
        cfg_req  = 1; cfg_we  = 0; cfg_addr  = NNW'(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wg_s[i] = work_gnt;
            cg_s[i] = cfg_gnt;
            tick();
            if (cg_s[i]) cfg_req = 0;
        end
        work_req = 0;
        @(negedge clk);
        check("t3_cfg_after_work", 32'(cfg_gnt), GUARD ? 32'd0 : 32'd1);
        tick();
        cfg_req = 0;
        for (int i = 0; i < 4; i++) begin
            check("t3_work_gnt", 32'(wg_s[i]), (GUARD && i == 3) ? 32'd0 : 32'd1);
            check("t3_cfg_gnt",  32'(cg_s[i]), (GUARD && i == 3) ? 32'd1 : 32'd0);
        end
        tick();

        // 4: sweep of 4 with work held
        work_req = 1; work_we = 0; work_addr = NNW'(7);
        clear_start = 1; neu_num = NNW'(4);
        for (int c = 1; c <= 6; c++) begin
            tick();
            clear_start = 0;
            @(negedge clk);
            check("t4_busy",     32'(clear_busy), 32'(c >= 1 && c <= 4));
            check("t4_work_gnt", 32'(work_gnt),   32'(c == 6));
            check("t4_done",     32'(clear_done), 32'(c == 5));
            if (c >= 2 && c <= 5) begin
                check("t4_mem_en",   32'(mem_en),   32'd1);
                check("t4_mem_we",   32'(mem_we),   32'd1);
                check("t4_mem_addr", 32'(mem_addr), 32'(c - 2));
            end
        end
        tick();
        work_req = 0;
        tick();

        // 5: zero-length sweep
        clear_start = 1; neu_num = '0;
        tick();
        clear_start = 0;
        @(negedge clk);
        check("t5_done",   32'(clear_done), 32'd1);
        check("t5_mem_en", 32'(mem_en),     32'd0);
        tick();
        @(negedge clk);
        check("t5_done_off", 32'(clear_done), 32'd0);
        check("t5_mem_we",   32'(mem_we),     32'd0);
        tick();

        // 6: reset in the middle of a sweep
        clear_start = 1; neu_num = NNW'(8);
        for (int c = 1; c <= 3; c++) begin
            tick();
            clear_start = 0;
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        check("t6_rst_mem_en", 32'(mem_en),     32'd0);
        check("t6_rst_busy",   32'(clear_busy), 32'd0);
        check("t6_rst_done",   32'(clear_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_done", 32'(clear_done), 32'd0);
            tick();
        end
        clear_start = 1; neu_num = NNW'(3);
        tick();
        clear_start = 0;
        tick();
        @(negedge clk);
        check("t6_restart_en",   32'(mem_en),   32'd1);
        check("t6_restart_we",   32'(mem_we),   32'd1);
        check("t6_restart_addr", 32'(mem_addr), 32'd0);
        repeat (5) tick();

        // randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!work_req || last_wg) begin
                work_req   = ($urandom_range(0, 2) != 0);
                work_we    = 1'($urandom_range(0, 1));
                work_addr  = NNW'($urandom_range(0, 15));
                work_wdata = VW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                work_req = 0;
            end
            if (!cfg_req || last_cg) begin
                cfg_req   = ($urandom_range(0, 2) != 0);
                cfg_we    = 1'($urandom_range(0, 1));
                cfg_addr  = NNW'($urandom_range(0, 15));
                cfg_wdata = VW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                cfg_req = 0;
            end
            clear_start = ($urandom_range(0, 59) == 0);
            neu_num     = NNW'($urandom_range(0, 6));
            tick();
        end
        work_req = 0; cfg_req = 0; clear_start = 0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time bound on the whole run
    initial begin : p_watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: run did not complete, actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
